// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, history depth and baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

   localparam int UART_BUF_DEPTH = 4;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; RST_VAL sets the level held during reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_history.sv
// 8N1 receiver with mid-bit sampling; good bytes shift into a four-entry history (index 3 newest).
//
//  state | meaning
//  IDLE  | line high, waiting for a start edge
//  START | counting to mid start bit, rejecting glitches
//  DATA  | sampling 8 data bits LSB-first at mid-bit
//  STOP  | sampling stop bit; commit or flag framing error
//  BREAK | stop bit was low; wait for the line to return high
module uart_rx_history
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 115_200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       RX,
   output logic [7:0] RXBUF [UART_BUF_DEPTH-1:0],
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       FRAME_ERR,
   output logic       RX_BUSY,
   output logic [2:0] RX_COUNT
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       CNT_MAX = 3'(UART_BUF_DEPTH);

   logic             w_rx_s;
   rx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bitn;
   logic [7:0]       r_sh;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .i_d     (RX),
      .o_q     (w_rx_s)
   );

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bitn    <= '0;
         r_sh      <= '0;
         RX_DATA   <= '0;
         RX_VALID  <= 1'b0;
         FRAME_ERR <= 1'b0;
         RX_COUNT  <= '0;
         for (int i = 0; i < UART_BUF_DEPTH; i++) RXBUF[i] <= '0;
      end else begin
         RX_VALID  <= 1'b0;
         FRAME_ERR <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  r_state <= START;
                  r_cnt   <= '0;
               end
            end
            START: begin
               if (r_cnt == CNT_MID) begin
                  r_cnt  <= '0;
                  r_bitn <= '0;
                  r_state <= w_rx_s ? IDLE : DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_cnt == CNT_END) begin
                  r_cnt  <= '0;
                  r_sh   <= {w_rx_s, r_sh[7:1]};
                  r_bitn <= r_bitn + 1'b1;
                  if (r_bitn == 3'd7) r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (r_cnt == CNT_END) begin
                  r_cnt   <= '0;
                  RX_DATA <= r_sh;
                  if (w_rx_s) begin
                     RX_VALID <= 1'b1;
                     RXBUF[UART_BUF_DEPTH-1] <= r_sh;
                     for (int i = 0; i < UART_BUF_DEPTH - 1; i++) RXBUF[i] <= RXBUF[i+1];
                     if (RX_COUNT < CNT_MAX) RX_COUNT <= RX_COUNT + 1'b1;
                     r_state <= IDLE;
                  end else begin
                     FRAME_ERR <= 1'b1;
                     r_state   <= BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            BREAK: begin
               if (w_rx_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign RX_BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_history.sv
// Scoreboard bench for uart_rx_history at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_history;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rxbuf [3:0];
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, rx_busy;
   logic [2:0] rx_count;

   uart_rx_history #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
      .CLK(clk), .RESET_N(rst_n), .RX(rx), .RXBUF(rxbuf), .RX_DATA(rx_data),
      .RX_VALID(rx_valid), .FRAME_ERR(frame_err), .RX_BUSY(rx_busy), .RX_COUNT(rx_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              is_err;
      logic [7:0]      data;
      logic [3:0][7:0] buf4;
      logic [2:0]      cnt;
      int              lat;
   } exp_t;

   exp_t            q[$];
   logic [3:0][7:0] m_buf = '0;
   logic [2:0]      m_cnt = '0;
   int              n_chk = 0, n_pass = 0;
   int              cyc = 0, t_fall = 0, n_valid = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_good(input logic [7:0] d, input int lat);
      exp_t e;
      m_buf = {d, m_buf[3:1]};
      if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
      e.is_err = 1'b0; e.data = d; e.buf4 = m_buf; e.cnt = m_cnt; e.lat = lat;
      q.push_back(e);
   endtask

   task automatic push_err(input logic [7:0] d);
      exp_t e;
      e.is_err = 1'b1; e.data = d; e.buf4 = m_buf; e.cnt = m_cnt; e.lat = 0;
      q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit, input real bit_ns,
                            input int stop_bits);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bit_ns);
      end
      rx = stop_bit;
      #(bit_ns * stop_bits);
      rx = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
      check(name, q.size(), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " rx_data"}, rx_data, 8'h00);
      check({tag, " rx_valid"}, rx_valid, 1'b0);
      check({tag, " frame_err"}, frame_err, 1'b0);
      check({tag, " rx_busy"}, rx_busy, 1'b0);
      check({tag, " rx_count"}, rx_count, 3'd0);
      for (int i = 0; i < 4; i++) check($sformatf("%s rxbuf[%0d]", tag, i), rxbuf[i], 8'h00);
   endtask

   // Monitor: every strobe pops one expected event.
   always @(negedge clk) begin
      if (rst_n && (rx_valid || frame_err)) begin
         if (rx_valid) n_valid++;
         if (rx_valid && frame_err) begin
            n_chk++;
            $display("FAIL strobe_overlap: got both RX_VALID and FRAME_ERR high, required one");
         end else if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_strobe: got valid=%0b ferr=%0b data=%0h, required none",
                     rx_valid, frame_err, rx_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("event_kind_ferr", frame_err, e.is_err);
            check("rx_data", rx_data, e.data);
            for (int i = 0; i < 4; i++) check($sformatf("rxbuf[%0d]", i), rxbuf[i], e.buf4[i]);
            check("rx_count", rx_count, e.cnt);
            if (e.lat > 0) check("valid_latency", cyc - t_fall, e.lat);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      real t0;
      logic [7:0] b;
      logic [7:0] seq [5];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // 1: single frame with latency check
      @(posedge clk); #1;
      t_fall = cyc;
      push_good(8'hA5, 155);
      send_byte(8'hA5, 1'b1, 160.0, 1);
      drain("t1_drain");
      #320;

      // 2: five back-to-back frames, history wraps
      v0 = n_valid;
      for (int i = 0; i < 5; i++) begin
         push_good(seq[i], 0);
         send_byte(seq[i], 1'b1, 160.0, 1);
      end
      drain("t2_drain");
      check("t2_valid_pulses", n_valid - v0, 5);
      check("t2_buf3", rxbuf[3], 8'h55);
      check("t2_buf2", rxbuf[2], 8'h44);
      check("t2_buf1", rxbuf[1], 8'h33);
      check("t2_buf0", rxbuf[0], 8'h22);
      check("t2_count", rx_count, 3'd4);
      #320;

      // 3: 4-clock glitch
      v0 = n_valid;
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t3_busy_in_start", rx_busy, 1'b1);
      rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("t3_busy_idle", rx_busy, 1'b0);
      check("t3_no_valid", n_valid - v0, 0);
      check("t3_buf3", rxbuf[3], 8'h55);

      // 4: framing error then a good frame
      push_err(8'h3C);
      send_byte(8'h3C, 1'b0, 160.0, 3);
      #320;
      push_good(8'h7E, 0);
      send_byte(8'h7E, 1'b1, 160.0, 1);
      drain("t4_drain");
      check("t4_buf0", rxbuf[0], 8'h33);
      #320;

      // 5: reset during bit 4 of frame E5 (bits 5..7 and stop are high)
      b = 8'hE5;
      rx = 1'b0;
      #160;
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         #160;
      end
      t0 = $realtime;
      rx = b[4];
      #40;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("midreset");
      #(t0 + 160.0 - $realtime);
      rx = b[5];
      #40;
      rst_n = 1'b1;
      #120;
      rx = b[6];
      #160;
      rx = b[7];
      #160;
      rx = 1'b1;
      #480;
      m_buf = '0;
      m_cnt = '0;
      check("t5_busy", rx_busy, 1'b0);
      check("t5_count", rx_count, 3'd0);
      check("t5_rx_data", rx_data, 8'h00);
      push_good(8'h81, 0);
      send_byte(8'h81, 1'b1, 160.0, 1);
      drain("t5_drain");
      #320;

      // 6: +/-3% baud skew
      push_good(8'hC3, 0);
      send_byte(8'hC3, 1'b1, 164.8, 1);
      #330;
      push_good(8'hC3, 0);
      send_byte(8'hC3, 1'b1, 155.2, 1);
      drain("t6_drain");
      check("t6_buf3", rxbuf[3], 8'hC3);
      check("t6_buf1", rxbuf[1], 8'h81);
      check("t6_count", rx_count, 3'd3);

      repeat (20) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
